// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared types for the PTW memory arbiter: cache request/response structs,
// arbiter state and owner encodings.
package ptw_mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
  } CacheReq;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
  } CacheResp;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D
  } memarb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } memarb_owner_t;

  function automatic memarb_state_t wait_state(input memarb_owner_t owner);
    return (owner == OWNER_D) ? WAIT_D : WAIT_I;
  endfunction

endpackage

// File: rtl/ptw_mem_arbiter_select.sv
// Two-way grant selection for the PTW memory arbiter.
// MEMARB_FIXED_PRIORITY_EN: data side always wins ties and no last-winner input exists.
module memarb_select
  import ptw_mem_arbiter_pkg::*;
(
  input  logic          ivalid,
  input  logic          dvalid,
  input  logic          lock,
  input  memarb_owner_t lock_owner,
`ifndef MEMARB_FIXED_PRIORITY_EN
  input  memarb_owner_t last,
`endif
  output memarb_owner_t grant,
  output logic          grant_valid
);

  always_comb begin
    grant = OWNER_I;
    if (lock) begin
      // a stalled request keeps the grant so memreq stays stable
      grant = lock_owner;
    end else if (ivalid && dvalid) begin
`ifdef MEMARB_FIXED_PRIORITY_EN
      grant = OWNER_D;
`else
      grant = (last == OWNER_I) ? OWNER_D : OWNER_I;
`endif
    end else if (dvalid) begin
      grant = OWNER_D;
    end else begin
      grant = OWNER_I;
    end
  end

  assign grant_valid = (grant == OWNER_D) ? dvalid : ivalid;

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Merges instruction- and data-side PTW cache streams onto one memory port,
// one outstanding transaction. Options: MEMARB_FIXED_PRIORITY_EN, PRINT_DEBUGINFO.
module ptw_mem_arbiter
  import ptw_mem_arbiter_pkg::*;
#(
  parameter int LOG_ENABLE = 0
) (
  input  logic     clk,
  input  logic     reset,
  input  CacheReq  ireq,
  output logic     ireq_ready,
  output CacheResp iresp,
  input  CacheReq  dreq,
  output logic     dreq_ready,
  output CacheResp dresp,
  output CacheReq  memreq,
  input  logic     memreq_ready,
  input  CacheResp memresp
);

  memarb_state_t state, state_next;
  logic          lock, lock_next;
  memarb_owner_t lock_owner, lock_owner_next;
  memarb_owner_t grant;
  logic          grant_valid;
  logic          accept;
  CacheReq       granted;
`ifndef MEMARB_FIXED_PRIORITY_EN
  memarb_owner_t last;
`endif

  memarb_select u_select (
    .ivalid      (ireq.valid),
    .dvalid      (dreq.valid),
    .lock        (lock),
    .lock_owner  (lock_owner),
`ifndef MEMARB_FIXED_PRIORITY_EN
    .last        (last),
`endif
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign granted = (grant == OWNER_D) ? dreq : ireq;

  always_comb begin
    state_next      = state;
    lock_next       = lock;
    lock_owner_next = lock_owner;
    accept          = 1'b0;
    memreq          = granted;
    memreq.valid    = 1'b0;
    ireq_ready      = 1'b0;
    dreq_ready      = 1'b0;
    iresp.valid     = 1'b0;
    iresp.rdata     = memresp.rdata;
    dresp.valid     = 1'b0;
    dresp.rdata     = memresp.rdata;

    unique case (state)
      IDLE: begin
        memreq.valid = grant_valid;
        ireq_ready   = (grant == OWNER_I) && memreq_ready;
        dreq_ready   = (grant == OWNER_D) && memreq_ready;
        accept       = grant_valid && memreq_ready;
        if (accept) begin
          state_next = wait_state(grant);
          lock_next  = 1'b0;
        end else if (grant_valid) begin
          lock_next       = 1'b1;
          lock_owner_next = grant;
        end else begin
          // requester withdrew: release the grant without issuing anything
          lock_next = 1'b0;
        end
      end
      WAIT_I: begin
        iresp.valid = memresp.valid;
        if (memresp.valid) state_next = IDLE;
      end
      WAIT_D: begin
        dresp.valid = memresp.valid;
        if (memresp.valid) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        lock_next  = 1'b0;
      end
    endcase

    if (reset) begin
      memreq.valid = 1'b0;
      ireq_ready   = 1'b0;
      dreq_ready   = 1'b0;
      iresp.valid  = 1'b0;
      dresp.valid  = 1'b0;
      accept       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lock       <= 1'b0;
      lock_owner <= OWNER_I;
`ifndef MEMARB_FIXED_PRIORITY_EN
      last       <= OWNER_I;
`endif
    end else begin
      state      <= state_next;
      lock       <= lock_next;
      lock_owner <= lock_owner_next;
`ifndef MEMARB_FIXED_PRIORITY_EN
      if (accept) last <= grant;
`endif
    end
  end

  if (LOG_ENABLE != 0) begin : g_log
`ifdef PRINT_DEBUGINFO
    always_ff @(posedge clk) begin
      $display("ptw_mem_arbiter: state=%s grant=%s lock=%0b", state.name(), grant.name(), lock);
    end
`endif
  end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_ptw_mem_arbiter;
  import ptw_mem_arbiter_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  CacheReq  ireq, dreq, memreq;
  CacheResp iresp, dresp, memresp;
  logic     ireq_ready, dreq_ready, memreq_ready;

  int total = 0;
  int bad   = 0;

  // reference model: who holds memory, who won last, who is holding a stalled grant
  bit busy  = 0;
  int own   = 0;
  int lastw = 0;
  bit hold  = 0;
  int holdw = 0;

  int       obs_acc;
  CacheReq  obs_memreq;
  CacheResp obs_iresp, obs_dresp;
  int       ipulses = 0, dpulses = 0;

  ptw_mem_arbiter #(.LOG_ENABLE(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq         (ireq),
    .ireq_ready   (ireq_ready),
    .iresp        (iresp),
    .dreq         (dreq),
    .dreq_ready   (dreq_ready),
    .dresp        (dresp),
    .memreq       (memreq),
    .memreq_ready (memreq_ready),
    .memresp      (memresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are set at the negedge; check combinational outputs, advance model, next negedge.
  task automatic step();
    int who;
    int tie;
    bit gv, e_ir, e_dr, e_mv, e_iv, e_dv;
    #1;
    who = 0; gv = 0; e_ir = 0; e_dr = 0; e_mv = 0; e_iv = 0; e_dv = 0;
`ifdef MEMARB_FIXED_PRIORITY_EN
    tie = 1;
`else
    tie = (lastw == 0) ? 1 : 0;
`endif
    if (!reset) begin
      if (!busy) begin
        if (hold) who = holdw;
        else if (ireq.valid && dreq.valid) who = tie;
        else who = dreq.valid ? 1 : 0;
        gv   = (who == 1) ? dreq.valid : ireq.valid;
        e_mv = gv;
        e_ir = (who == 0) && memreq_ready;
        e_dr = (who == 1) && memreq_ready;
      end else begin
        e_iv = (own == 0) && memresp.valid;
        e_dv = (own == 1) && memresp.valid;
      end
    end

    obs_memreq = memreq;
    obs_iresp  = iresp;
    obs_dresp  = dresp;
    obs_acc    = -1;
    if (ireq.valid && ireq_ready) obs_acc = 0;
    if (dreq.valid && dreq_ready) obs_acc = 1;
    ipulses += int'(iresp.valid);
    dpulses += int'(dresp.valid);

    chk("ireq_ready", ireq_ready, e_ir);
    chk("dreq_ready", dreq_ready, e_dr);
    chk("memreq_valid", memreq.valid, e_mv);
    chk("iresp_valid", iresp.valid, e_iv);
    chk("dresp_valid", dresp.valid, e_dv);
    if (e_mv) begin
      chk("memreq_addr", memreq.addr, (who == 1) ? dreq.addr : ireq.addr);
      chk("memreq_wdata", memreq.wdata, (who == 1) ? dreq.wdata : ireq.wdata);
      chk("memreq_wen", memreq.wen, (who == 1) ? dreq.wen : ireq.wen);
    end
    if (e_iv) chk("iresp_rdata", iresp.rdata, memresp.rdata);
    if (e_dv) chk("dresp_rdata", dresp.rdata, memresp.rdata);

    if (reset) begin
      busy = 0; hold = 0; lastw = 0;
    end else if (!busy) begin
      if (gv && memreq_ready) begin
        busy = 1; own = who; lastw = who; hold = 0;
      end else if (gv) begin
        hold = 1; holdw = who;
      end else begin
        hold = 0;
      end
    end else if (memresp.valid) begin
      busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    ireq.valid = 0; dreq.valid = 0; memresp.valid = 0; memreq_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    int ip0, dp0;
    int exp_g;
    reset = 1;
    ireq = '0; dreq = '0; memresp = '0; memreq_ready = 0;
    @(negedge clk);
    // stale memory response during and after reset must be dropped
    memresp.valid = 1; memresp.rdata = 32'h1234_5678;
    ireq.valid = 1; dreq.valid = 1; memreq_ready = 1;
    step(); step();
    chk("reset_memreq_valid", obs_memreq.valid, 0);
    reset = 0; quiet(); memresp.valid = 1;
    step();
    chk("stale_iresp", obs_iresp.valid, 0);
    chk("stale_dresp", obs_dresp.valid, 0);

    // single instruction-side access, response three cycles after accept
    quiet(); ip0 = ipulses; dp0 = dpulses;
    ireq.valid = 1; ireq.addr = 32'h8000_1000; ireq.wen = 0; ireq.wdata = 32'h0;
    step();
    chk("t1_accept", obs_acc, 0);
    chk("t1_addr", obs_memreq.addr, 32'h8000_1000);
    ireq.valid = 0;
    step(); step();
    memresp.valid = 1; memresp.rdata = 32'hDEAD_BEEF;
    step();
    chk("t1_rdata", obs_iresp.rdata, 32'hDEAD_BEEF);
    memresp.valid = 0; step();
    chk("t1_ipulses", ipulses - ip0, 1);
    chk("t1_dpulses", dpulses - dp0, 0);

    // tie from reset, four times
    quiet(); do_reset();
    ireq.addr = 32'h0000_1110; dreq.addr = 32'h0000_2220;
    for (int k = 0; k < 4; k++) begin
      ireq.valid = 1; dreq.valid = 1; memreq_ready = 1; memresp.valid = 0;
      step();
`ifdef MEMARB_FIXED_PRIORITY_EN
      exp_g = 1;
`else
      exp_g = (k % 2 == 0) ? 1 : 0;
`endif
      chk("tie_grant", obs_acc, exp_g);
      memresp.valid = 1; memresp.rdata = 32'hA000_0000 + k;
      step();
    end

    // stalled I request keeps the grant while D arrives
    quiet(); step();
    ireq.valid = 1; ireq.addr = 32'h8000_3000; memreq_ready = 0;
    dreq.addr = 32'h8000_4000;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) dreq.valid = 1;
      step();
      chk("lock_addr", obs_memreq.addr, 32'h8000_3000);
    end
    memreq_ready = 1; step();
    chk("lock_i_first", obs_acc, 0);
    ireq.valid = 0; memresp.valid = 1; step();
    memresp.valid = 0; step();
    chk("lock_d_next", obs_acc, 1);
    dreq.valid = 0; memresp.valid = 1; step();

    // accepted D blocks pending I until response; I accepted afterwards
    quiet(); dreq.valid = 1; dreq.addr = 32'h8000_5000;
    step();
    chk("blk_d_accept", obs_acc, 1);
    dreq.valid = 0; ireq.valid = 1; ireq.addr = 32'h8000_6000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("blk_iready", obs_acc, -1);
      chk("blk_memvalid", obs_memreq.valid, 0);
    end
    memresp.valid = 1; step();
    chk("blk_resp_cycle", obs_acc, -1);
    memresp.valid = 0; step();
    chk("blk_i_after", obs_acc, 0);
    ireq.valid = 0; memresp.valid = 1; step();

    // reset in WAIT_D drops the pending response
    quiet(); ip0 = ipulses; dp0 = dpulses;
    dreq.valid = 1; dreq.addr = 32'h8000_7000; step();
    dreq.valid = 0; step();
    do_reset();
    step(); memresp.valid = 1; step();
    memresp.valid = 0;
    chk("rst_ipulses", ipulses - ip0, 0);
    chk("rst_dpulses", dpulses - dp0, 0);
    ireq.valid = 1; ireq.addr = 32'h8000_8000; step();
    chk("rst_i_accept", obs_acc, 0);
    ireq.valid = 0; memresp.valid = 1; memresp.rdata = 32'h0BAD_F00D; step();
    chk("rst_i_resp", obs_iresp.rdata, 32'h0BAD_F00D);
    chk("rst_i_pulse", ipulses - ip0, 1);

    // D withdrawn while locked: nothing issued, I granted afterwards
    quiet(); memreq_ready = 0; dreq.valid = 1; dreq.addr = 32'h8000_9000; step();
    ireq.valid = 1; ireq.addr = 32'h8000_A000; step();
    chk("wd_hold_d", obs_memreq.addr, 32'h8000_9000);
    dreq.valid = 0; step();
    chk("wd_no_issue", obs_memreq.valid, 0);
    memreq_ready = 1; step();
    chk("wd_i_granted", obs_acc, 0);
    ireq.valid = 0; memresp.valid = 1; step();

    // randomized traffic
    quiet();
    for (int n = 0; n < 3000; n++) begin
      if (obs_acc == 0 || !ireq.valid || $urandom_range(0, 19) == 0) begin
        ireq.valid = ($urandom_range(0, 9) < 4);
        ireq.addr = $urandom; ireq.wdata = $urandom; ireq.wen = $urandom_range(0, 1);
      end
      if (obs_acc == 1 || !dreq.valid || $urandom_range(0, 19) == 0) begin
        dreq.valid = ($urandom_range(0, 9) < 4);
        dreq.addr = $urandom; dreq.wdata = $urandom; dreq.wen = $urandom_range(0, 1);
      end
      memreq_ready  = ($urandom_range(0, 3) != 0);
      memresp.valid = busy ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 5);
      memresp.rdata = $urandom;
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
